pc_attack_sequencer: RTL and testbench

Sequences the computer's attack during the PC turn of the battleship game. It picks a pseudo-random board cell and rejects off-board or already-shot cells. It reads the player's board memory, writes back hit or miss, and keeps the count of player ship cells still afloat. It then pulses `pc_move` so the game FSM can return to the player turn. It sits between the game FSM (`pc_turn` → `start`, `pc_move`/`player_ships` ← outputs) and the player board RAM.

---
 rtl/pc_attack_sequencer_if.sv | 28 ++
 rtl/pc_attack_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pc_attack_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_attack_sequencer_if.sv
// Player board RAM port: sequencer drives address and strobes, RAM returns cell code.
// Synchronous read with one cycle of latency; a write commits on the edge where brd_wr_en is high.
interface pc_attack_sequencer_if;
  logic       brd_rd_en;
  logic [2:0] brd_addr_row;
  logic [2:0] brd_addr_col;
  logic [1:0] brd_rd_data;
  logic       brd_wr_en;
  logic [1:0] brd_wr_data;

  modport master (
    output brd_rd_en,
    output brd_addr_row,
    output brd_addr_col,
    output brd_wr_en,
    output brd_wr_data,
    input  brd_rd_data
  );

  modport slave (
    input  brd_rd_en,
    input  brd_addr_row,
    input  brd_addr_col,
    input  brd_wr_en,
    input  brd_wr_data,
    output brd_rd_data
  );
endinterface

// File: rtl/pc_attack_sequencer.sv
// PC attack sequencer: random target pick, board read-modify-write, ship bookkeeping, pc_move pulse.
// Latency >= 5 cycles from the start edge (1 when no target is left); no backpressure, the RAM answers every cycle.
module pc_attack_sequencer #(
  parameter int         BOARD_W   = 5,
  parameter int         BOARD_H   = 5,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      ships_load,
  input  logic [4:0]                ships_init,
  pc_attack_sequencer_if.master     brd,
  output logic                      hit,
  output logic                      miss,
  output logic                      pc_move,
  output logic                      busy,
  output logic [4:0]                player_ships
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PICK  = 3'd1,
    READ  = 3'd2,
    EVAL  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [6:0] CELLS = 7'(BOARD_W * BOARD_H);
  localparam logic [3:0] ROWS  = 4'(BOARD_H);
  localparam logic [3:0] COLS  = 4'(BOARD_W);

  localparam logic [1:0] CODE_WATER = 2'b00;
  localparam logic [1:0] CODE_SHIP  = 2'b01;
  localparam logic [1:0] CODE_MISS  = 2'b10;
  localparam logic [1:0] CODE_HIT   = 2'b11;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] lfsr;
  logic       lfsr_fb;
  logic       start_q;
  logic [6:0] shots;
  logic [2:0] row_q;
  logic [2:0] col_q;
  logic [1:0] code_q;
  logic       trigger;
  logic       cand_ok;
  logic       ship_struck;

  // Fibonacci LFSR, taps 8,6,5,4; free-running so the pick depends on when the turn starts.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  assign trigger     = start & ~start_q;
  assign cand_ok     = ({1'b0, lfsr[2:0]} < ROWS) && ({1'b0, lfsr[5:3]} < COLS);
  assign ship_struck = (code_q == CODE_SHIP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    brd.brd_rd_en    = 1'b0;
    brd.brd_wr_en    = 1'b0;
    brd.brd_wr_data  = 2'b00;
    hit              = 1'b0;
    miss             = 1'b0;
    pc_move          = 1'b0;
    busy             = (state != IDLE);

    case (state)
      IDLE: begin
        // A load owns the cycle: any start edge arriving with it is discarded.
        if (!ships_load && trigger) begin
          state_nxt = (shots < CELLS) ? PICK : DONE;
        end
      end
      PICK: begin
        if (cand_ok) begin
          state_nxt = READ;
        end
      end
      READ: begin
        brd.brd_rd_en = 1'b1;
        state_nxt     = EVAL;
      end
      EVAL: begin
        // Cells already carrying a miss/hit mark are re-picked.
        state_nxt = brd.brd_rd_data[1] ? PICK : WRITE;
      end
      WRITE: begin
        brd.brd_wr_en   = 1'b1;
        brd.brd_wr_data = ship_struck ? CODE_HIT : CODE_MISS;
        hit             = ship_struck;
        miss            = ~ship_struck;
        state_nxt       = DONE;
      end
      DONE: begin
        pc_move   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q        <= 3'd0;
      col_q        <= 3'd0;
      code_q       <= CODE_WATER;
      shots        <= 7'd0;
      player_ships <= 5'd0;
    end else begin
      if (state == IDLE && ships_load) begin
        player_ships <= ships_init;
        shots        <= 7'd0;
      end
      if (state == PICK && cand_ok) begin
        row_q <= lfsr[2:0];
        col_q <= lfsr[5:3];
      end
      if (state == EVAL) begin
        code_q <= brd.brd_rd_data;
      end
      if (state == WRITE) begin
        shots <= shots + 7'd1;
        if (ship_struck && player_ships != 5'd0) begin
          player_ships <= player_ships - 5'd1;
        end
      end
    end
  end

  assign brd.brd_addr_row = row_q;
  assign brd.brd_addr_col = col_q;

endmodule

// File: tb/tb_pc_attack_sequencer.sv
// Directed bench for pc_attack_sequencer with a behavioural board RAM and event counters.
module tb_pc_attack_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ships_load;
  logic [4:0] ships_init;
  logic       hit;
  logic       miss;
  logic       pc_move;
  logic       busy;
  logic [4:0] player_ships;

  pc_attack_sequencer_if bus();

  pc_attack_sequencer #(
    .BOARD_W  (5),
    .BOARD_H  (5),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ships_load  (ships_load),
    .ships_init  (ships_init),
    .brd         (bus),
    .hit         (hit),
    .miss        (miss),
    .pc_move     (pc_move),
    .busy        (busy),
    .player_ships(player_ships)
  );

  always #5 clk = ~clk;

  localparam int LIMIT = 1000;

  // Board RAM model; the fill port rewrites the whole board in one cycle.
  logic [1:0] mem [0:7][0:7];
  logic       fill_req = 1'b0;
  logic [1:0] fill_val = 2'b00;
  logic [1:0] fill_spec = 2'b00;
  logic [2:0] fill_r = 3'd7;
  logic [2:0] fill_c = 3'd7;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          mem[r][c] <= (r == int'(fill_r) && c == int'(fill_c)) ? fill_spec : fill_val;
    end else begin
      if (bus.brd_rd_en) bus.brd_rd_data <= mem[bus.brd_addr_row][bus.brd_addr_col];
      if (bus.brd_wr_en) mem[bus.brd_addr_row][bus.brd_addr_col] <= bus.brd_wr_data;
    end
  end

  int n_rd = 0, n_rd_water = 0, n_wr = 0, n_hit = 0, n_miss = 0, n_move = 0, n_bad = 0;
  int last_wr_row = -1, last_wr_col = -1, last_wr_data = -1;

  always @(negedge clk) begin
    if (bus.brd_rd_en) begin
      n_rd <= n_rd + 1;
      if (mem[bus.brd_addr_row][bus.brd_addr_col] == 2'b00) n_rd_water <= n_rd_water + 1;
    end
    if (bus.brd_wr_en) begin
      n_wr         <= n_wr + 1;
      last_wr_row  <= int'(bus.brd_addr_row);
      last_wr_col  <= int'(bus.brd_addr_col);
      last_wr_data <= int'(bus.brd_wr_data);
    end
    if ((bus.brd_rd_en || bus.brd_wr_en) && (bus.brd_addr_row >= 3'd5 || bus.brd_addr_col >= 3'd5))
      n_bad <= n_bad + 1;
    if (hit)     n_hit  <= n_hit + 1;
    if (miss)    n_miss <= n_miss + 1;
    if (pc_move) n_move <= n_move + 1;
  end

  int tests = 0;
  int fails = 0;
  int b_rd, b_rd_water, b_wr, b_hit, b_miss, b_move, b_bad;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_rd = n_rd; b_rd_water = n_rd_water; b_wr = n_wr; b_hit = n_hit;
    b_miss = n_miss; b_move = n_move; b_bad = n_bad;
  endtask

  task automatic fill(input logic [1:0] v, input logic [2:0] r, input logic [2:0] c, input logic [1:0] sv);
    @(negedge clk);
    fill_val = v; fill_r = r; fill_c = c; fill_spec = sv; fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  task automatic load(input int n);
    @(negedge clk);
    ships_load = 1'b1; ships_init = 5'(n);
    @(negedge clk);
    ships_load = 1'b0;
  endtask

  // lat = cycles from the sampled start edge to pc_move, -1 if it never came.
  task automatic run_attack(output int lat, output int ships_at_move);
    lat = -1;
    ships_at_move = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (pc_move) begin
        lat = k;
        ships_at_move = int'(player_ships);
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, sam, ok, lat_bad, found;
    rst = 1'b1; start = 1'b0; ships_load = 1'b0; ships_init = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy",     int'(busy), 0);
    chk("rst_rd_en",    int'(bus.brd_rd_en), 0);
    chk("rst_wr_en",    int'(bus.brd_wr_en), 0);
    chk("rst_hit",      int'(hit), 0);
    chk("rst_miss",     int'(miss), 0);
    chk("rst_pc_move",  int'(pc_move), 0);
    chk("rst_ships",    int'(player_ships), 0);
    chk("rst_row",      int'(bus.brd_addr_row), 0);
    chk("rst_col",      int'(bus.brd_addr_col), 0);
    chk("rst_wr_data",  int'(bus.brd_wr_data), 0);
    rst = 1'b0;

    // All ships: one hit, count drops to 24.
    fill(2'b01, 3'd7, 3'd7, 2'b01);
    load(25);
    chk("t1_loaded", int'(player_ships), 25);
    snap();
    run_attack(lat, sam);
    chk("t1_lat_ge5",    int'(lat >= 5), 1);
    chk("t1_writes",     n_wr - b_wr, 1);
    chk("t1_wr_data",    last_wr_data, 3);
    chk("t1_hits",       n_hit - b_hit, 1);
    chk("t1_misses",     n_miss - b_miss, 0);
    chk("t1_moves",      n_move - b_move, 1);
    chk("t1_ships_move", sam, 24);
    chk("t1_ships",      int'(player_ships), 24);
    chk("t1_bad_addr",   n_bad - b_bad, 0);

    // Only (2,3) is water; everything else already shot.
    fill(2'b10, 3'd2, 3'd3, 2'b00);
    load(7);
    ok = 0;
    for (int a = 0; a < 6 && ok == 0; a++) begin
      snap();
      run_attack(lat, sam);
      if (lat > 0) ok = 1;
      else begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        load(7);
        repeat (a + 1) @(negedge clk);
      end
    end
    chk("t2_completed",  ok, 1);
    chk("t2_writes",     n_wr - b_wr, 1);
    chk("t2_wr_row",     last_wr_row, 2);
    chk("t2_wr_col",     last_wr_col, 3);
    chk("t2_wr_data",    last_wr_data, 2);
    chk("t2_misses",     n_miss - b_miss, 1);
    chk("t2_hits",       n_hit - b_hit, 0);
    chk("t2_water_rds",  n_rd_water - b_rd_water, 1);
    chk("t2_bad_addr",   n_bad - b_bad, 0);
    chk("t2_ships_move", sam, 7);
    chk("t2_cell",       int'(mem[2][3]), 2);

    // 25 attacks on a freshly watered board each time, then no target left.
    load(3);
    snap();
    lat_bad = 0;
    for (int i = 0; i < 25; i++) begin
      fill(2'b00, 3'd7, 3'd7, 2'b00);
      run_attack(lat, sam);
      if (lat < 5) lat_bad++;
    end
    chk("t3_lat_bad", lat_bad, 0);
    chk("t3_writes",  n_wr - b_wr, 25);
    chk("t3_misses",  n_miss - b_miss, 25);
    chk("t3_hits",    n_hit - b_hit, 0);
    chk("t3_ships",   int'(player_ships), 3);
    snap();
    run_attack(lat, sam);
    chk("t3_full_lat",    lat, 1);
    chk("t3_full_reads",  n_rd - b_rd, 0);
    chk("t3_full_writes", n_wr - b_wr, 0);
    chk("t3_full_moves",  n_move - b_move, 1);

    // Last ship sunk, then saturation at zero.
    fill(2'b01, 3'd7, 3'd7, 2'b01);
    load(1);
    snap();
    run_attack(lat, sam);
    chk("t4_ships_zero", int'(player_ships), 0);
    chk("t4_hits",       n_hit - b_hit, 1);
    load(0);
    snap();
    run_attack(lat, sam);
    chk("t4_sat_ships",  int'(player_ships), 0);
    chk("t4_sat_hits",   n_hit - b_hit, 1);
    chk("t4_sat_writes", n_wr - b_wr, 1);
    chk("t4_sat_data",   last_wr_data, 3);

    // start held high for 40 cycles gives one turn only.
    load(10);
    snap();
    @(negedge clk);
    start = 1'b1;
    repeat (40) @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < LIMIT && busy; k++) @(negedge clk);
    @(negedge clk);
    chk("t6_moves",  n_move - b_move, 1);
    chk("t6_writes", n_wr - b_wr, 1);

    // Load and start edge together: load wins, no attack.
    snap();
    @(negedge clk);
    ships_load = 1'b1; ships_init = 5'd9; start = 1'b1;
    @(negedge clk);
    ships_load = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_load_ships", int'(player_ships), 9);
    chk("t6_load_busy",  int'(busy), 0);
    chk("t6_load_moves", n_move - b_move, 0);
    chk("t6_load_reads", n_rd - b_rd, 0);
    start = 1'b0;
    @(negedge clk);

    // Reset while in EVAL abandons the attack.
    load(4);
    snap();
    @(negedge clk);
    start = 1'b1;
    found = 0;
    for (int k = 0; k < LIMIT && found == 0; k++) begin
      @(negedge clk);
      if (bus.brd_rd_en) found = 1;
    end
    chk("t5_reached_read", found, 1);
    @(negedge clk);
    chk("t5_in_eval_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_idle_busy",  int'(busy), 0);
    chk("t5_idle_ships", int'(player_ships), 0);
    rst = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_writes", n_wr - b_wr, 0);
    chk("t5_moves",  n_move - b_move, 0);
    chk("t5_hits",   n_hit - b_hit, 0);
    chk("t5_misses", n_miss - b_miss, 0);
    chk("t5_ships",  int'(player_ships), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
